// File: rtl/wgt_fifo_ctrl.sv
// Weight FIFO controller: clears, loads and reads out the systolic weight FIFOs for one layer.
// Optional multi-pass reuse of loaded weights is enabled with macro WGT_CTRL_REUSE_EN.
module wgt_fifo_ctrl #(
  parameter int NUM_FIFO          = 16,
  parameter int MAX_WGT_FIFO_SIZE = 4608,
  parameter int CNT_WIDTH         = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_wgt,
  input  logic [4:0]           read_wgt_size,
  input  logic [7:0]           num_reuse,
  input  logic                 wgt_valid,
  input  logic                 read_go,
  output logic                 wr_clr,
  output logic                 rd_clr,
  output logic                 wr_en,
  output logic [NUM_FIFO-1:0]  rd_en,
  output logic                 load_done,
  output logic                 done,
  output logic                 busy
);

  // One extra bit: a read pass spans num_wgt + NUM_FIFO - 1 cycles.
  localparam int CW = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] WOne = 1;
  localparam logic [CW-1:0]        COne = 1;

  typedef enum logic [2:0] {
    StIdle, StClr, StLoad, StWait, StRead, StRewind, StFin
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   nwgt_q, nwgt_d;
  logic [CW-1:0]          ncol_q, ncol_d;
  logic [CNT_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]          rcyc_q, rcyc_d;
  logic                   load_done_q, load_done_d;
  logic [NUM_FIFO-1:0]    rd_en_q, rd_en_d;
  logic                   rd_active;
  logic [CW-1:0]          read_len;

`ifdef WGT_CTRL_REUSE_EN
  logic [7:0]             reuse_q, reuse_d;
  logic [7:0]             pass_q, pass_d;
`else
  logic                   unused_reuse;
  assign unused_reuse = ^num_reuse;
`endif

  assign read_len = {1'b0, nwgt_q} + ncol_q - COne;

  always_comb begin
    state_d     = state_q;
    nwgt_d      = nwgt_q;
    ncol_d      = ncol_q;
    wcnt_d      = wcnt_q;
    rcyc_d      = rcyc_q;
    load_done_d = 1'b0;
    rd_active   = 1'b0;
    wr_clr      = 1'b0;
    rd_clr      = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    busy        = (state_q != StIdle);
`ifdef WGT_CTRL_REUSE_EN
    reuse_d     = reuse_q;
    pass_d      = pass_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Oversized requests are clamped to the physical FIFO depth.
          nwgt_d = (int'(num_wgt) > MAX_WGT_FIFO_SIZE) ? CNT_WIDTH'(MAX_WGT_FIFO_SIZE) : num_wgt;
          ncol_d = (read_wgt_size == 5'd0 || int'(read_wgt_size) > NUM_FIFO) ?
                   CW'(NUM_FIFO) : CW'(read_wgt_size);
`ifdef WGT_CTRL_REUSE_EN
          reuse_d = num_reuse;
`endif
          state_d = StClr;
        end
      end

      StClr: begin
        wr_clr = 1'b1;
        rd_clr = 1'b1;
        wcnt_d = '0;
        rcyc_d = '0;
`ifdef WGT_CTRL_REUSE_EN
        pass_d = '0;
`endif
        state_d = (nwgt_q == '0) ? StFin : StLoad;
      end

      StLoad: begin
        wr_en = wgt_valid;
        if (wgt_valid) begin
          wcnt_d = wcnt_q + WOne;
          if (wcnt_q == nwgt_q - WOne) begin
            load_done_d = 1'b1;
            state_d     = StWait;
          end
        end
      end

      StWait: begin
        if (read_go) begin
          rcyc_d    = '0;
          rd_active = 1'b1;
          state_d   = StRead;
        end
      end

      StRead: begin
        if (rcyc_q == read_len - COne) begin
          rcyc_d = '0;
`ifdef WGT_CTRL_REUSE_EN
          state_d = (pass_q < reuse_q) ? StRewind : StFin;
`else
          state_d = StFin;
`endif
        end else begin
          rcyc_d    = rcyc_q + COne;
          rd_active = 1'b1;
        end
      end

      StRewind: begin
        rd_clr  = 1'b1;
`ifdef WGT_CTRL_REUSE_EN
        pass_d  = pass_q + 8'd1;
`endif
        state_d = StWait;
      end

      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Column i reads during pass cycles i .. i+num_wgt-1; registered, so use next cycle index.
    for (int i = 0; i < NUM_FIFO; i++) begin
      rd_en_d[i] = rd_active && (rcyc_d >= CW'(i)) &&
                   ((rcyc_d - CW'(i)) < {1'b0, nwgt_q}) && (CW'(i) < ncol_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      nwgt_q      <= '0;
      ncol_q      <= '0;
      wcnt_q      <= '0;
      rcyc_q      <= '0;
      load_done_q <= 1'b0;
      rd_en_q     <= '0;
`ifdef WGT_CTRL_REUSE_EN
      reuse_q     <= '0;
      pass_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      nwgt_q      <= nwgt_d;
      ncol_q      <= ncol_d;
      wcnt_q      <= wcnt_d;
      rcyc_q      <= rcyc_d;
      load_done_q <= load_done_d;
      rd_en_q     <= rd_en_d;
`ifdef WGT_CTRL_REUSE_EN
      reuse_q     <= reuse_d;
      pass_q      <= pass_d;
`endif
    end
  end

  assign load_done = load_done_q;
  assign rd_en     = rd_en_q;

endmodule

// File: tb/tb_wgt_fifo_ctrl.sv
// Directed self-checking bench for wgt_fifo_ctrl; reuse expectations follow WGT_CTRL_REUSE_EN.
module tb_wgt_fifo_ctrl;
  localparam int NF = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [12:0]   num_wgt;
  logic [4:0]    read_wgt_size;
  logic [7:0]    num_reuse;
  logic          wgt_valid;
  logic          read_go;
  logic          wr_clr, rd_clr, wr_en, load_done, done, busy;
  logic [NF-1:0] rd_en;

  int checks = 0;
  int errors = 0;

  int n_wr, first_wr, last_wr, n_ld, ld_cyc, n_done, done_cyc, n_wrclr, n_rdclr;
  int rd_first[NF];
  int rd_last[NF];
  int rd_cnt[NF];
  int r0;

  wgt_fifo_ctrl #(.NUM_FIFO(NF), .MAX_WGT_FIFO_SIZE(4608), .CNT_WIDTH(13)) dut (
    .clk(clk), .rst(rst), .start(start), .num_wgt(num_wgt), .read_wgt_size(read_wgt_size),
    .num_reuse(num_reuse), .wgt_valid(wgt_valid), .read_go(read_go), .wr_clr(wr_clr),
    .rd_clr(rd_clr), .wr_en(wr_en), .rd_en(rd_en), .load_done(load_done), .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the CLR cycle; records every output event per cycle until done.
  task automatic run_layer(input int nw, input int sz, input int reuse, input bit toggle,
                           input bit poke, input int budget);
    int cyc;
    bit fin;
    n_wr = 0; first_wr = -1; last_wr = -1; n_ld = 0; ld_cyc = -1;
    n_done = 0; done_cyc = -1; n_wrclr = 0; n_rdclr = 0;
    for (int j = 0; j < NF; j++) begin
      rd_first[j] = -1; rd_last[j] = -1; rd_cnt[j] = 0;
    end
    @(posedge clk); #1;
    start = 1'b1; num_wgt = 13'(nw); read_wgt_size = 5'(sz); num_reuse = 8'(reuse);
    wgt_valid = 1'b0; read_go = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < budget) begin
      wgt_valid = toggle ? ((cyc % 2) == 1) : 1'b1;
      read_go   = 1'b1;
      if (poke && cyc == 3) begin
        start = 1'b1; num_wgt = 13'd2; read_wgt_size = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (wr_en) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (load_done) begin n_ld++; ld_cyc = cyc; end
      if (wr_clr) n_wrclr++;
      if (rd_clr) n_rdclr++;
      for (int j = 0; j < NF; j++) begin
        if (rd_en[j]) begin
          if (rd_first[j] < 0) rd_first[j] = cyc;
          rd_last[j] = cyc;
          rd_cnt[j]++;
        end
      end
      if (done) begin
        n_done++; done_cyc = cyc; fin = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; wgt_valid = 1'b0; read_go = 1'b0;
    check("done_reached", int'(fin), 1);
    @(negedge clk);
    check("busy_after_fin", int'(busy), 0);
    r0 = rd_first[0];
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_wgt = '0; read_wgt_size = '0; num_reuse = '0;
    wgt_valid = 1'b1; read_go = 1'b1;
    #12;
    check("rst_wr_clr", int'(wr_clr), 0);
    check("rst_rd_clr", int'(rd_clr), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic full-width layer
    run_layer(4, 16, 0, 1'b0, 1'b0, 200);
    check("a_wrclr", n_wrclr, 1);
    check("a_wr_cnt", n_wr, 4);
    check("a_wr_first", first_wr, 1);
    check("a_ld_cnt", n_ld, 1);
    check("a_ld_cyc", ld_cyc, 5);
    check("a_r0", r0, 6);
    check("a_rd0_last", rd_last[0], r0 + 3);
    check("a_rd15_first", rd_first[15], r0 + 15);
    check("a_rd15_last", rd_last[15], r0 + 18);
    check("a_rd7_cnt", rd_cnt[7], 4);
    check("a_done_cnt", n_done, 1);
    check("a_done_cyc", done_cyc, r0 + 19);

    // Narrow layer: five columns
    run_layer(3, 5, 0, 1'b0, 1'b0, 200);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("b_rd%0d_first", j), rd_first[j], r0 + j);
      check($sformatf("b_rd%0d_cnt", j), rd_cnt[j], 3);
    end
    for (int j = 5; j < NF; j++) check($sformatf("b_rd%0d_off", j), rd_cnt[j], 0);
    check("b_done_cyc", done_cyc, r0 + 7);

    // Toggling wgt_valid, with a start poked mid-LOAD that must be ignored
    run_layer(6, 16, 0, 1'b1, 1'b1, 200);
    check("c_wr_cnt", n_wr, 6);
    check("c_wr_first", first_wr, 1);
    check("c_wr_last", last_wr, 11);
    check("c_ld_cyc", ld_cyc, 12);
    check("c_ld_cnt", n_ld, 1);
    check("c_rd15_cnt", rd_cnt[15], 6);
    check("c_done_cnt", n_done, 1);

    // Out-of-range column counts select all columns
    run_layer(2, 0, 0, 1'b0, 1'b0, 200);
    check("d_sz0_rd15", rd_cnt[15], 2);
    run_layer(2, 20, 0, 1'b0, 1'b0, 200);
    check("d_sz20_rd15", rd_cnt[15], 2);
    check("d_sz20_done", done_cyc, r0 + 17);

    // Reuse passes
    run_layer(2, 2, 2, 1'b0, 1'b0, 300);
`ifdef WGT_CTRL_REUSE_EN
    check("e_rd0_cnt", rd_cnt[0], 6);
    check("e_rd1_cnt", rd_cnt[1], 6);
    check("e_rdclr_cnt", n_rdclr, 3);
`else
    check("e_rd0_cnt", rd_cnt[0], 2);
    check("e_rd1_cnt", rd_cnt[1], 2);
    check("e_rdclr_cnt", n_rdclr, 1);
    check("e_done_cyc", done_cyc, r0 + 3);
`endif
    check("e_wrclr_cnt", n_wrclr, 1);
    check("e_done_cnt", n_done, 1);

    // Empty layer
    run_layer(0, 8, 0, 1'b0, 1'b0, 50);
    check("f_wr_cnt", n_wr, 0);
    check("f_rd0_cnt", rd_cnt[0], 0);
    check("f_ld_cnt", n_ld, 0);
    check("f_wrclr", n_wrclr, 1);
    check("f_done_cyc", done_cyc, 1);

    // Reset on READ cycle 2
    begin
      bit seen;
      seen = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; num_wgt = 13'd4; read_wgt_size = 5'd16; num_reuse = 8'd0;
      @(posedge clk); #1;
      start = 1'b0; wgt_valid = 1'b1; read_go = 1'b1;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        if (rd_en[0]) seen = 1'b1;
      end
      check("g_read_seen", int'(seen), 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("g_pre_rst_rd_en", int'(rd_en), 32'h7);
      rst = 1'b1;
      #1;
      check("g_rst_rd_en", int'(rd_en), 0);
      check("g_rst_busy", int'(busy), 0);
      check("g_rst_wr_en", int'(wr_en), 0);
      check("g_rst_clr", int'(wr_clr | rd_clr), 0);
      check("g_rst_pulses", int'(done | load_done), 0);
      @(negedge clk);
      rst = 1'b0;
    end
    run_layer(3, 5, 0, 1'b0, 1'b0, 200);
    check("h_wr_cnt", n_wr, 3);
    check("h_rd4_first", rd_first[4], r0 + 4);
    check("h_rd5_cnt", rd_cnt[5], 0);
    check("h_done_cyc", done_cyc, r0 + 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wgt_fifo_ctrl.md
WGT_FIFO_CTRL -- requirements
Module: wgt_fifo_ctrl

Interface
REQ-001 SHALL have parameter NUM_FIFO, default 16, meaning the number of weight FIFO columns driven.
REQ-002 SHALL have parameter MAX_WGT_FIFO_SIZE, default 4608, meaning the maximum weight words per FIFO.
REQ-003 SHALL have parameter CNT_WIDTH, default 13, meaning the word-counter width (must hold MAX_WGT_FIFO_SIZE).
REQ-004 SHALL have ports: clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have ports: rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have ports: start  input  1  one-cycle request to begin a layer.
REQ-007 SHALL have ports: num_wgt  input  CNT_WIDTH  weight words per FIFO for this layer.
REQ-008 SHALL have ports: read_wgt_size  input  5  active columns, 1..16.
REQ-009 SHALL have ports: num_reuse  input  8  extra read passes over loaded weights.
REQ-010 SHALL have ports: wgt_valid  input  1  a weight word (all columns) is on the FIFO data bus.
REQ-011 SHALL have ports: read_go  input  1  array ready to consume one read pass.
REQ-012 SHALL have ports: wr_clr, rd_clr, wr_en  output  1 each  FIFO control.
REQ-013 SHALL have ports: rd_en  output  NUM_FIFO  per-column FIFO read enable.
REQ-014 SHALL have ports: load_done, done  output  1 each  one-cycle pulses; busy  output  1  not IDLE.

Function
REQ-015 SHALL implement states IDLE, CLR, LOAD, WAIT, READ, REWIND, FIN.
REQ-016 IDLE: start=1 SHALL latch num_wgt, read_wgt_size, num_reuse and go to CLR; start in any other state SHALL be ignored.
REQ-017 Latched read_wgt_size of 0 or >NUM_FIFO SHALL be treated as NUM_FIFO.
REQ-018 CLR: wr_clr=rd_clr=1 for exactly one cycle; next LOAD, or FIN if latched num_wgt=0 (no wr_en/rd_en ever asserted).
REQ-019 LOAD: wr_en SHALL equal wgt_valid combinationally (zero latency); word counter increments per accepted word.
REQ-020 When the num_wgt-th word is accepted, load_done SHALL pulse the following cycle and the state SHALL move to WAIT; further wgt_valid SHALL not assert wr_en.
REQ-021 WAIT: read_go=1 SHALL enter READ next cycle; READ lasts exactly num_wgt+N-1 cycles, N = effective column count.
REQ-022 rd_en[i] (registered) SHALL be high during READ cycles i .. i+num_wgt-1 (cycle 0 = first READ cycle) for i<N, and always 0 for i>=N (systolic skew of one cycle per column).
REQ-023 End of READ: if pass count < latched num_reuse, go to REWIND (rd_clr=1 one cycle, pass count+1) then WAIT; otherwise FIN.
REQ-024 FIN: done=1 for one cycle, then IDLE; busy SHALL be 1 in every state except IDLE.
REQ-025 read_go outside WAIT SHALL be ignored; wgt_valid outside LOAD SHALL be ignored.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, all counters 0, and wr_clr, rd_clr, wr_en, rd_en, load_done, done, busy to 0, including mid-LOAD or mid-READ.
REQ-027 After rst deasserts, the block SHALL accept start on the first clock edge.

Configuration
REQ-028 With macro WGT_CTRL_REUSE_EN defined, num_reuse SHALL behave per REQ-023.
REQ-029 Without WGT_CTRL_REUSE_EN, num_reuse SHALL be ignored, REWIND SHALL be unreachable, and READ end SHALL always go to FIN.

Verification
REQ-030 num_wgt=4, size=16, wgt_valid continuous, read_go held -> 4 wr_en cycles, load_done once, rd_en[0] high cycles 0-3, rd_en[15] high cycles 15-18, done once.
REQ-031 num_wgt=3, size=5 -> rd_en[4:0] staggered 3-cycle windows, rd_en[15:5] never high; READ lasts 7 cycles.
REQ-032 wgt_valid toggling 1010..., num_wgt=6 -> exactly 6 wr_en cycles over 11 cycles, load_done after the 6th.
REQ-033 WGT_CTRL_REUSE_EN, num_reuse=2 -> three READ passes, two rd_clr pulses in REWIND, one done; without macro -> one pass.
REQ-034 rst asserted on READ cycle 2 -> all outputs 0 same cycle, IDLE; new start runs a clean layer; start during LOAD ignored.
REQ-035 num_wgt=0 -> clear pulse, then done, no wr_en or rd_en.
